// File: rtl/ps2_kbd_receiver.sv
// ps2_kbd_receiver
// Receives 11-bit PS/2 keyboard frames (start, 8 data LSB first, odd parity,
// stop). Each accepted scan code is presented as a level handshake: the
// kbd_data_ready output is held high for READY_CYCLES clocks and then low
// for READY_CYCLES clocks. A one-entry pending buffer absorbs a code that
// arrives while a presentation is in progress.
// Optional feature macro: PS2_BREAK_FILTER_EN. When it is defined, break
// sequences (F0 xx) and E0 prefixes are dropped, so only make codes are
// presented.
module ps2_kbd_receiver #(
    parameter int READY_CYCLES   = 16,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] kbd_code,
    output logic       kbd_data_ready,
    output logic       frame_error,
    output logic       overrun
);

    localparam int RW = $clog2(READY_CYCLES) + 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [RW-1:0] READY_LAST   = RW'(READY_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_t;

    typedef enum logic [1:0] {
        OUT_IDLE,
        OUT_HIGH,
        OUT_GAP
    } out_state_t;

    // ------------------------------------------------------------------
    // Synchronisers and falling-edge detect
    // ------------------------------------------------------------------
    logic ps2_clk_meta_q;
    logic ps2_clk_sync_q;
    logic ps2_clk_prev_q;
    logic ps2_data_meta_q;
    logic ps2_data_sync_q;
    logic ps2_fall;

    // Two-flop synchronisers on both pins plus one history flop for edge detect;
    // everything idles high like the bus itself.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ps2_clk_meta_q  <= 1'b1;
            ps2_clk_sync_q  <= 1'b1;
            ps2_clk_prev_q  <= 1'b1;
            ps2_data_meta_q <= 1'b1;
            ps2_data_sync_q <= 1'b1;
        end else begin
            ps2_clk_meta_q  <= ps2_clk;
            ps2_clk_sync_q  <= ps2_clk_meta_q;
            ps2_clk_prev_q  <= ps2_clk_sync_q;
            ps2_data_meta_q <= ps2_data;
            ps2_data_sync_q <= ps2_data_meta_q;
        end
    end

    assign ps2_fall = ps2_clk_prev_q & ~ps2_clk_sync_q;

    // ------------------------------------------------------------------
    // Receive FSM
    // ------------------------------------------------------------------
    rx_state_t     rx_state_q, rx_state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          rx_accept;
    logic          rx_error;

    // Receive state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_state_q <= RX_IDLE;
            bit_cnt_q  <= 3'd0;
            shift_q    <= 8'h00;
            parity_q   <= 1'b0;
            tmo_cnt_q  <= '0;
        end else begin
            rx_state_q <= rx_state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

    // Frame decode: one bit per ps2_clk fall, with an inactivity timeout mid-frame.
    // rx_accept/rx_error are single-cycle strobes on the stop-bit fall (or timeout).
    always_comb begin
        rx_state_d = rx_state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        tmo_cnt_d  = tmo_cnt_q;
        rx_accept  = 1'b0;
        rx_error   = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                tmo_cnt_d = '0;
                // A fall with data high is a glitch, not a start bit.
                if (ps2_fall && !ps2_data_sync_q) begin
                    rx_state_d = RX_DATA;
                    bit_cnt_d  = 3'd0;
                end
            end
            default: begin
                if (ps2_fall) begin
                    tmo_cnt_d = '0;
                    case (rx_state_q)
                        RX_DATA: begin
                            shift_d   = {ps2_data_sync_q, shift_q[7:1]};
                            bit_cnt_d = bit_cnt_q + 3'd1;
                            if (bit_cnt_q == 3'd7) begin
                                rx_state_d = RX_PARITY;
                            end
                        end
                        RX_PARITY: begin
                            parity_d   = ps2_data_sync_q;
                            rx_state_d = RX_STOP;
                        end
                        RX_STOP: begin
                            if (ps2_data_sync_q && (^{shift_q, parity_q})) begin
                                rx_accept = 1'b1;
                            end else begin
                                rx_error = 1'b1;
                            end
                            rx_state_d = RX_IDLE;
                        end
                        default: rx_state_d = RX_IDLE;
                    endcase
                end else if (tmo_cnt_q == TIMEOUT_LAST) begin
                    rx_error   = 1'b1;
                    rx_state_d = RX_IDLE;
                    tmo_cnt_d  = '0;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Optional break/extended-prefix filter
    // ------------------------------------------------------------------
    logic present;

`ifdef PS2_BREAK_FILTER_EN
    logic brk_q, brk_d;

    // Break flag register: set by F0, consumed by the following byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            brk_q <= 1'b0;
        end else begin
            brk_q <= brk_d;
        end
    end

    // Only make codes pass; E0 prefixes are dropped without touching the flag.
    always_comb begin
        brk_d   = brk_q;
        present = 1'b0;
        if (rx_error) begin
            brk_d = 1'b0;
        end else if (rx_accept) begin
            if (shift_q == 8'hF0) begin
                brk_d = 1'b1;
            end else if (shift_q == 8'hE0) begin
                brk_d = brk_q;
            end else if (brk_q) begin
                brk_d = 1'b0;
            end else begin
                present = 1'b1;
            end
        end
    end
`else
    assign present = rx_accept;
`endif

    // ------------------------------------------------------------------
    // Output stage: level handshake plus one-entry pending buffer
    // ------------------------------------------------------------------
    out_state_t    out_state_q, out_state_d;
    logic [RW-1:0] out_cnt_q, out_cnt_d;
    logic [7:0]    code_q, code_d;
    logic          ready_q, ready_d;
    logic [7:0]    pend_q, pend_d;
    logic          pend_full_q, pend_full_d;
    logic          frame_error_q;
    logic          overrun_q, overrun_d;

    // Output stage register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_state_q   <= OUT_IDLE;
            out_cnt_q     <= '0;
            code_q        <= 8'h00;
            ready_q       <= 1'b0;
            pend_q        <= 8'h00;
            pend_full_q   <= 1'b0;
            frame_error_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            out_state_q   <= out_state_d;
            out_cnt_q     <= out_cnt_d;
            code_q        <= code_d;
            ready_q       <= ready_d;
            pend_q        <= pend_d;
            pend_full_q   <= pend_full_d;
            frame_error_q <= rx_error;
            overrun_q     <= overrun_d;
        end
    end

    // Presentation sequencing. kbd_code is only reloaded when ready rises,
    // so it never moves while the consumer may be sampling it.
    always_comb begin
        out_state_d = out_state_q;
        out_cnt_d   = out_cnt_q;
        code_d      = code_q;
        ready_d     = ready_q;
        pend_d      = pend_q;
        pend_full_d = pend_full_q;
        overrun_d   = 1'b0;
        case (out_state_q)
            OUT_IDLE: begin
                if (present) begin
                    code_d      = shift_q;
                    ready_d     = 1'b1;
                    out_cnt_d   = '0;
                    out_state_d = OUT_HIGH;
                end
            end
            OUT_HIGH: begin
                if (out_cnt_q == READY_LAST) begin
                    ready_d     = 1'b0;
                    out_cnt_d   = '0;
                    out_state_d = OUT_GAP;
                end else begin
                    out_cnt_d = out_cnt_q + RW'(1);
                end
                if (present) begin
                    pend_d      = shift_q;
                    pend_full_d = 1'b1;
                    overrun_d   = pend_full_q;
                end
            end
            OUT_GAP: begin
                if (out_cnt_q == READY_LAST) begin
                    out_cnt_d = '0;
                    if (pend_full_q) begin
                        // Older pending byte goes out first; a coincident
                        // new byte takes its place in the buffer.
                        code_d      = pend_q;
                        ready_d     = 1'b1;
                        out_state_d = OUT_HIGH;
                        pend_full_d = present;
                        if (present) begin
                            pend_d = shift_q;
                        end
                    end else if (present) begin
                        code_d      = shift_q;
                        ready_d     = 1'b1;
                        out_state_d = OUT_HIGH;
                    end else begin
                        out_state_d = OUT_IDLE;
                    end
                end else begin
                    out_cnt_d = out_cnt_q + RW'(1);
                    if (present) begin
                        pend_d      = shift_q;
                        pend_full_d = 1'b1;
                        overrun_d   = pend_full_q;
                    end
                end
            end
            default: begin
                out_state_d = OUT_IDLE;
                ready_d     = 1'b0;
            end
        endcase
    end

    assign kbd_code       = code_q;
    assign kbd_data_ready = ready_q;
    assign frame_error    = frame_error_q;
    assign overrun        = overrun_q;

endmodule
